// File: rtl/il1_inclusion_scheduler.sv
// Back-invalidation sequencer keeping IL1 inclusive of L2: arbitrates the inst/data
// L2 replace requesters, performs read-compare-clear on one IL1 set, then handshakes the ack.
module il1_inclusion_scheduler #(
  parameter int LINES  = 128,
  parameter int WAYS   = 4,
  parameter int TAG_W  = 20,
  localparam int IDX_W  = $clog2(LINES),
  localparam int ADDR_W = TAG_W + IDX_W
) (
  input  logic                  clk_l1,
  input  logic                  rst_n,
  input  logic                  inst_inv_req,
  input  logic [ADDR_W-1:0]     inst_inv_addr,
  output logic                  inst_inv_ack,
  input  logic                  inst_l2_ack,
  input  logic                  data_inv_req,
  input  logic [ADDR_W-1:0]     data_inv_addr,
  output logic                  data_inv_ack,
  input  logic                  data_l2_ack,
  input  logic                  refill_busy,
  output logic                  port_sel,
  output logic [IDX_W-1:0]      inv_index,
  input  logic [WAYS*TAG_W-1:0] tag_rd,
  input  logic [WAYS-1:0]       valid_rd,
  output logic [WAYS-1:0]       clear_way,
  output logic                  busy,
  output logic [15:0]           clr_cnt
);

  typedef enum logic [1:0] {IDLE, RD, CMP, ACK} state_t;
  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_t;

  state_t              state_q, state_d;
  src_t                src_q;
  src_t                last_q;
  logic                pend_inst_q, pend_data_q;
  logic [ADDR_W-1:0]   addr_inst_q, addr_data_q;
  logic [TAG_W-1:0]    inv_tag_q;

  logic                cand_inst, cand_data;
  logic                grant;
  src_t                grant_src;
  logic [ADDR_W-1:0]   grant_addr;
  logic [WAYS-1:0]     hit;
  logic                l2_ack_sel;
  logic                ack_done;
  logic                cmp_ok;

  // A live request bypasses the pending register so an idle block grants at the req edge.
  assign cand_inst = pend_inst_q | inst_inv_req;
  assign cand_data = pend_data_q | data_inv_req;
  assign grant     = (state_q == IDLE) && !refill_busy && (cand_inst || cand_data);

  // On a tie the source not served last wins; last_q only moves on ack completion.
  assign grant_src = (cand_inst && (!cand_data || last_q == SRC_DATA)) ? SRC_INST : SRC_DATA;

  always_comb begin
    grant_addr = '0;
    if (grant_src == SRC_INST) grant_addr = pend_inst_q ? addr_inst_q : inst_inv_addr;
    else                       grant_addr = pend_data_q ? addr_data_q : data_inv_addr;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_hit
    assign hit[w] = valid_rd[w] && (tag_rd[w*TAG_W +: TAG_W] == inv_tag_q);
  end

  assign l2_ack_sel = (src_q == SRC_INST) ? inst_l2_ack : data_l2_ack;
  assign ack_done   = (state_q == ACK) && l2_ack_sel;
  assign cmp_ok     = (state_q == CMP) && !refill_busy;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clear_way = '0;
    unique case (state_q)
      IDLE: if (grant) state_d = RD;
      RD:   state_d = refill_busy ? IDLE : CMP;
      CMP: begin
        if (refill_busy) begin
          state_d = IDLE;
        end else begin
          clear_way = hit;
          state_d   = ACK;
        end
      end
      ACK:  if (l2_ack_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign port_sel = (state_q == RD) || (state_q == CMP);
  assign busy     = (state_q != IDLE);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= SRC_INST;
      last_q    <= SRC_DATA;
      inv_index <= '0;
      inv_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        src_q     <= grant_src;
        inv_index <= grant_addr[IDX_W-1:0];
        inv_tag_q <= grant_addr[ADDR_W-1:IDX_W];
      end
      if (ack_done) last_q <= src_q;
    end
  end

  // A source stays pending through service, which also blocks duplicate requests.
  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      pend_inst_q <= 1'b0;
      pend_data_q <= 1'b0;
      addr_inst_q <= '0;
      addr_data_q <= '0;
    end else begin
      if (inst_inv_req && !pend_inst_q) begin
        pend_inst_q <= 1'b1;
        addr_inst_q <= inst_inv_addr;
      end else if (ack_done && src_q == SRC_INST) begin
        pend_inst_q <= 1'b0;
      end
      if (data_inv_req && !pend_data_q) begin
        pend_data_q <= 1'b1;
        addr_data_q <= data_inv_addr;
      end else if (ack_done && src_q == SRC_DATA) begin
        pend_data_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      inst_inv_ack <= 1'b0;
      data_inv_ack <= 1'b0;
    end else begin
      if (cmp_ok && src_q == SRC_INST)        inst_inv_ack <= 1'b1;
      else if (ack_done && src_q == SRC_INST) inst_inv_ack <= 1'b0;
      if (cmp_ok && src_q == SRC_DATA)        data_inv_ack <= 1'b1;
      else if (ack_done && src_q == SRC_DATA) data_inv_ack <= 1'b0;
    end
  end

  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n)                               clr_cnt <= '0;
    else if (clear_way != '0 && clr_cnt != 16'hFFFF) clr_cnt <= clr_cnt + 16'd1;
  end

  a_ack_onehot: assert property (@(posedge clk_l1) disable iff (!rst_n)
    !(inst_inv_ack && data_inv_ack));
  a_clear_in_cmp: assert property (@(posedge clk_l1) disable iff (!rst_n)
    (clear_way != '0) |-> (state_q == CMP));

endmodule

// File: tb/tb_il1_inclusion_scheduler.sv
// Bench for il1_inclusion_scheduler: behavioural IL1 tag/valid array, scoreboard of
// expected (source, index, clear mask) completions checked at each ack rise.
module tb_il1_inclusion_scheduler;
  localparam int LINES = 128, WAYS = 4, TAG_W = 20, IDX_W = 7, ADDR_W = 27;

  logic clk_l1 = 1'b0, rst_n = 1'b0;
  logic inst_inv_req = 0, data_inv_req = 0, inst_l2_ack = 0, data_l2_ack = 0, refill_busy = 0;
  logic [ADDR_W-1:0] inst_inv_addr = '0, data_inv_addr = '0;
  logic inst_inv_ack, data_inv_ack, port_sel, busy;
  logic [IDX_W-1:0] inv_index;
  logic [WAYS*TAG_W-1:0] tag_rd;
  logic [WAYS-1:0] valid_rd, clear_way;
  logic [15:0] clr_cnt;

  il1_inclusion_scheduler #(.LINES(LINES), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk_l1(clk_l1), .rst_n(rst_n),
    .inst_inv_req(inst_inv_req), .inst_inv_addr(inst_inv_addr), .inst_inv_ack(inst_inv_ack),
    .inst_l2_ack(inst_l2_ack),
    .data_inv_req(data_inv_req), .data_inv_addr(data_inv_addr), .data_inv_ack(data_inv_ack),
    .data_l2_ack(data_l2_ack),
    .refill_busy(refill_busy), .port_sel(port_sel), .inv_index(inv_index),
    .tag_rd(tag_rd), .valid_rd(valid_rd), .clear_way(clear_way), .busy(busy), .clr_cnt(clr_cnt)
  );

  always #5 clk_l1 = ~clk_l1;

  int n_tests = 0, n_fail = 0;

  // IL1 array model: one-cycle read latency, valid clear taken at the CMP-ending edge.
  logic [TAG_W-1:0] m_tag   [LINES][WAYS];
  logic             m_valid [LINES][WAYS];
  logic [IDX_W-1:0] rd_idx = '0;

  always @(posedge clk_l1) begin
    rd_idx <= inv_index;
    for (int w = 0; w < WAYS; w++) if (clear_way[w]) m_valid[inv_index][w] <= 1'b0;
  end

  always_comb begin
    tag_rd   = '0;
    valid_rd = '0;
    for (int w = 0; w < WAYS; w++) begin
      tag_rd[w*TAG_W +: TAG_W] = m_tag[rd_idx][w];
      valid_rd[w]              = m_valid[rd_idx][w];
    end
  end

  typedef struct packed {
    logic             src;
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  mask;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = '0;

  // Monitor: accumulate what the DUT did during RD/CMP, compare on each ack rise.
  logic [IDX_W-1:0] cur_idx = '0;
  logic [WAYS-1:0]  cur_mask = '0;
  logic             prev_i = 0, prev_d = 0;

  always @(negedge clk_l1) begin
    if (!rst_n) begin
      cur_mask = '0; prev_i = 0; prev_d = 0;
    end else begin
      exp_t e, o;
      if (port_sel) cur_idx = inv_index;
      cur_mask = cur_mask | clear_way;
      if ((inst_inv_ack && !prev_i) || (data_inv_ack && !prev_d)) begin
        o = '{src: data_inv_ack, idx: cur_idx, mask: cur_mask};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_ack got src=%0d idx=%0d mask=%b want no ack", o.src, o.idx, o.mask);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL sb_completion got src=%0d idx=%0d mask=%b want src=%0d idx=%0d mask=%b",
                     o.src, o.idx, o.mask, e.src, e.idx, e.mask);
          end
        end
        cur_mask = '0;
      end
      prev_i = inst_inv_ack;
      prev_d = data_inv_ack;
    end
  end

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] tag, input int idx);
    logic [IDX_W-1:0] i;
    i = idx[IDX_W-1:0];
    return {tag, i};
  endfunction

  // All ways valid; ways in mask hold tag, others hold a different tag.
  task automatic set_line(input int idx, input logic [TAG_W-1:0] tag, input logic [WAYS-1:0] mask);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[idx][w] = 1'b1;
      m_tag[idx][w]   = mask[w] ? tag : tag ^ TAG_W'(w + 1);
    end
  endtask

  task automatic push_exp(input logic src, input int idx, input logic [WAYS-1:0] mask);
    exp_q.push_back('{src: src, idx: idx[IDX_W-1:0], mask: mask});
    if (mask != '0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic apply_reset();
    rst_n = 0; inst_inv_req = 0; data_inv_req = 0; inst_l2_ack = 0; data_l2_ack = 0; refill_busy = 0;
    repeat (2) @(negedge clk_l1);
    rst_n = 1;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  // One-cycle request pulse(s); returns at the negedge after the sampling edge.
  task automatic issue(input logic do_i, input logic [ADDR_W-1:0] ai,
                       input logic do_d, input logic [ADDR_W-1:0] ad);
    @(negedge clk_l1);
    inst_inv_req = do_i; inst_inv_addr = ai;
    data_inv_req = do_d; data_inv_addr = ad;
    @(negedge clk_l1);
    inst_inv_req = 0; data_inv_req = 0;
  endtask

  task automatic wait_ack(input logic src);
    logic seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      seen = src ? data_inv_ack : inst_inv_ack;
      if (!seen) @(negedge clk_l1);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_timeout src=%0d got ack=0 want 1", src);
    end else begin
      if (src) data_l2_ack = 1; else inst_l2_ack = 1;
      @(negedge clk_l1);
      inst_l2_ack = 0; data_l2_ack = 0;
      n_tests++;
      if ((src ? data_inv_ack : inst_inv_ack) !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_drop src=%0d got ack=1 want 0", src);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    for (int i = 0; i < LINES; i++) for (int w = 0; w < WAYS; w++) begin
      m_valid[i][w] = 1'b0; m_tag[i][w] = '0;
    end
    #2;
    obs = {inst_inv_ack, data_inv_ack, port_sel, inv_index, clear_way, busy, clr_cnt};
    n_tests++;
    if (obs !== 32'h0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", obs); end
    apply_reset();
    @(negedge clk_l1);
    obs = {inst_inv_ack, data_inv_ack, port_sel, inv_index, clear_way, busy, clr_cnt};
    n_tests++;
    if (obs !== 32'h0) begin n_fail++; $display("FAIL idle_after_reset got %h want 0", obs); end
  endtask

  task automatic test_single_hit();
    set_line(7, 20'h12345, 4'b0100);
    push_exp(0, 7, 4'b0100);
    issue(1, mk_addr(20'h12345, 7), 0, '0);
    n_tests++;
    if ({busy, port_sel, inv_index, inst_inv_ack} !== {1'b1, 1'b1, 7'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL hit_rd got busy=%b sel=%b idx=%0d ack=%b want 1 1 7 0", busy, port_sel, inv_index, inst_inv_ack);
    end
    @(negedge clk_l1);
    n_tests++;
    if ({port_sel, clear_way, inst_inv_ack} !== {1'b1, 4'b0100, 1'b0}) begin
      n_fail++;
      $display("FAIL hit_cmp got sel=%b clear=%b ack=%b want 1 0100 0", port_sel, clear_way, inst_inv_ack);
    end
    @(negedge clk_l1);
    n_tests++;
    if ({port_sel, clear_way, inst_inv_ack} !== {1'b0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL hit_ack got sel=%b clear=%b ack=%b want 0 0000 1", port_sel, clear_way, inst_inv_ack);
    end
    inst_l2_ack = 1;
    @(negedge clk_l1);
    inst_l2_ack = 0;
    n_tests++;
    if ({inst_inv_ack, busy, clr_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL hit_done got ack=%b busy=%b cnt=%0d want 0 0 1", inst_inv_ack, busy, clr_cnt);
    end
  endtask

  task automatic test_miss();
    set_line(9, 20'hABCDE, 4'b0000);
    push_exp(1, 9, 4'b0000);
    issue(0, '0, 1, mk_addr(20'hABCDE, 9));
    wait_ack(1);
    n_tests++;
    if (clr_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL miss_cnt got %0d want %0d", clr_cnt, exp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    set_line(10, 20'h0AAAA, 4'b0001);
    set_line(11, 20'h0BBBB, 4'b0101);
    push_exp(0, 10, 4'b0001);
    push_exp(1, 11, 4'b0101);
    issue(1, mk_addr(20'h0AAAA, 10), 1, mk_addr(20'h0BBBB, 11));
    wait_ack(0);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    @(negedge clk_l1);
    n_tests++;
    if ({busy, port_sel, inv_index} !== {1'b1, 1'b1, 7'd11}) begin
      n_fail++;
      $display("FAIL b2b_grant got busy=%b sel=%b idx=%0d want 1 1 11", busy, port_sel, inv_index);
    end
    wait_ack(1);
    // Inst served alone, so the next tie must go to data.
    set_line(12, 20'h0CCCC, 4'b1000);
    push_exp(0, 12, 4'b1000);
    issue(1, mk_addr(20'h0CCCC, 12), 0, '0);
    wait_ack(0);
    set_line(13, 20'h0DDDD, 4'b0010);
    set_line(14, 20'h0EEEE, 4'b0100);
    push_exp(1, 14, 4'b0100);
    push_exp(0, 13, 4'b0010);
    issue(1, mk_addr(20'h0DDDD, 13), 1, mk_addr(20'h0EEEE, 14));
    wait_ack(1);
    wait_ack(0);
    n_tests++;
    if (clr_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL rr_cnt got %0d want %0d", clr_cnt, exp_cnt);
    end
  endtask

  task automatic test_refill();
    logic any_busy = 0;
    set_line(40, 20'h44444, 4'b0010);
    refill_busy = 1;
    issue(1, mk_addr(20'h44444, 40), 0, '0);
    repeat (4) begin any_busy |= busy; @(negedge clk_l1); end
    n_tests++;
    if (any_busy !== 1'b0) begin n_fail++; $display("FAIL refill_block got busy=1 want 0"); end
    refill_busy = 0;
    @(negedge clk_l1);
    n_tests++;
    if ({busy, port_sel, inv_index} !== {1'b1, 1'b1, 7'd40}) begin
      n_fail++;
      $display("FAIL refill_release got busy=%b sel=%b idx=%0d want 1 1 40", busy, port_sel, inv_index);
    end
    refill_busy = 1;
    @(negedge clk_l1);
    n_tests++;
    if ({busy, m_valid[40][1]} !== 2'b01) begin
      n_fail++; $display("FAIL rd_abort got busy=%b valid=%b want 0 1", busy, m_valid[40][1]);
    end
    @(negedge clk_l1);
    refill_busy = 0;
    push_exp(0, 40, 4'b0010);
    wait_ack(0);
  endtask

  task automatic test_duplicate();
    logic seen = 0, any_busy = 0;
    set_line(20, 20'h22222, 4'b0010);
    set_line(21, 20'h22222, 4'b0010);
    push_exp(0, 20, 4'b0010);
    issue(1, mk_addr(20'h22222, 20), 0, '0);
    for (int k = 0; k < 10 && !seen; k++) begin
      seen = inst_inv_ack;
      if (!seen) @(negedge clk_l1);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL dup_ack got ack=0 want 1"); end
    inst_inv_req = 1; inst_inv_addr = mk_addr(20'h22222, 21);
    @(negedge clk_l1);
    inst_inv_req = 0; inst_l2_ack = 1;
    @(negedge clk_l1);
    inst_l2_ack = 0;
    repeat (6) begin any_busy |= busy; @(negedge clk_l1); end
    n_tests++;
    if ({any_busy, m_valid[20][1], m_valid[21][1]} !== 3'b001) begin
      n_fail++;
      $display("FAIL dup_ignored got busy=%b v20=%b v21=%b want 0 0 1", any_busy, m_valid[20][1], m_valid[21][1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    logic any_act = 0;
    set_line(30, 20'h33333, 4'b0010);
    issue(1, mk_addr(20'h33333, 30), 0, '0);
    @(posedge clk_l1);
    #2 rst_n = 0;
    #1;
    obs = {inst_inv_ack, data_inv_ack, port_sel, inv_index, clear_way, busy, clr_cnt};
    n_tests++;
    if (obs !== 32'h0) begin n_fail++; $display("FAIL reset_mid got %h want 0", obs); end
    @(negedge clk_l1);
    rst_n = 1;
    exp_cnt = '0;
    repeat (6) begin any_act |= busy | inst_inv_ack | data_inv_ack; @(negedge clk_l1); end
    n_tests++;
    if ({any_act, m_valid[30][1]} !== 2'b01) begin
      n_fail++; $display("FAIL reset_lost got act=%b valid=%b want 0 1", any_act, m_valid[30][1]);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk_l1);
    force dut.clr_cnt = 16'hFFFE;
    #1 release dut.clr_cnt;
    exp_cnt = 16'hFFFE;
    for (int n = 0; n < 2; n++) begin
      set_line(50 + n, 20'h55555, 4'b1001);
      push_exp(1, 50 + n, 4'b1001);
      issue(0, '0, 1, mk_addr(20'h55555, 50 + n));
      wait_ack(1);
      n_tests++;
      if (clr_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL sat_cnt%0d got %h want %h", n, clr_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_simultaneous();
    test_refill();
    test_duplicate();
    test_reset_mid();
    test_saturation();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
